// File: rtl/dma_rd_engine.sv
// dma_rd_engine: AXI3 read DMA fetching a programmable beat count into a valid/ready stream.
// Bursts are clipped to BURST_LEN, the remaining length, and the next 4 KB page boundary.
module dma_rd_engine #(
    parameter int          DATA_WIDTH = 64,
    parameter int          BURST_LEN  = 16,
    parameter int          LEN_WIDTH  = 24,
    parameter logic [2:0]  AXI_ID     = 3'b100,
    parameter logic [3:0]  AR_CACHE   = 4'b0001
) (
    input  logic                  m_axi_acp_aclk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic [31:0]           src_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           m_axi_acp_araddr,
    output logic [3:0]            m_axi_acp_arlen,
    output logic                  m_axi_acp_arvalid,
    input  logic                  m_axi_acp_arready,
    output logic [2:0]            m_axi_acp_arid,
    output logic [2:0]            m_axi_acp_arsize,
    output logic [1:0]            m_axi_acp_arburst,
    output logic [1:0]            m_axi_acp_arlock,
    output logic [3:0]            m_axi_acp_arcache,
    output logic [2:0]            m_axi_acp_arprot,
    output logic [3:0]            m_axi_acp_arqos,
    output logic [4:0]            m_axi_acp_aruser,
    input  logic [DATA_WIDTH-1:0] m_axi_acp_rdata,
    input  logic [1:0]            m_axi_acp_rresp,
    input  logic                  m_axi_acp_rlast,
    input  logic                  m_axi_acp_rvalid,
    output logic                  m_axi_acp_rready,
    output logic [DATA_WIDTH-1:0] mm2s_data,
    output logic                  mm2s_valid,
    input  logic                  mm2s_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] rem, rem_n;
    logic [4:0]           bcnt, beats, first_beats, next_beats;
    logic [31:0]          start_addr, addr_n;
    logic                 beat_ok, last_ok, beat_err;

    function automatic logic [4:0] burst_beats(input logic [31:0] a, input logic [LEN_WIDTH-1:0] r);
        logic [12:0] page;
        logic [4:0]  b;
        page = (13'd4096 - {1'b0, a[11:0]}) >> SIZE;
        b = 5'(BURST_LEN);
        if (page < 13'(b)) b = page[4:0];
        if (r < LEN_WIDTH'(b)) b = r[4:0];
        return b;
    endfunction

    // araddr/arlen double as the working address and current burst size
    assign start_addr  = src_addr & ~32'(BYTES - 1);
    assign beats       = {1'b0, m_axi_acp_arlen} + 5'd1;
    assign addr_n      = m_axi_acp_araddr + (32'(beats) << SIZE);
    assign rem_n       = rem - LEN_WIDTH'(beats);
    assign first_beats = burst_beats(start_addr, length);
    assign next_beats  = burst_beats(addr_n, rem_n);
    assign beat_ok     = state == DATA && m_axi_acp_rvalid && mm2s_ready;
    assign last_ok     = beat_ok && m_axi_acp_rlast;
    assign beat_err    = m_axi_acp_rresp != 2'b00 ||
                         (m_axi_acp_rlast ? bcnt + 5'd1 != beats : bcnt + 5'd1 == beats);

    assign busy              = state != IDLE;
    assign done              = state == DONE;
    assign m_axi_acp_arvalid = state == ADDR;
    assign m_axi_acp_rready  = state == DATA && mm2s_ready;
    assign mm2s_valid        = state == DATA && m_axi_acp_rvalid;
    assign mm2s_data         = m_axi_acp_rdata;

    assign m_axi_acp_arid    = AXI_ID;
    assign m_axi_acp_arsize  = 3'(SIZE);
    assign m_axi_acp_arburst = 2'b01;
    assign m_axi_acp_arlock  = 2'b00;
    assign m_axi_acp_arcache = AR_CACHE;
    assign m_axi_acp_arprot  = 3'b010;
    assign m_axi_acp_arqos   = 4'b0000;
    assign m_axi_acp_aruser  = 5'b00000;

    always_ff @(posedge m_axi_acp_aclk) begin
        if (axi_reset) begin
            state            <= IDLE;
            rem              <= '0;
            bcnt             <= '0;
            error            <= 1'b0;
            m_axi_acp_araddr <= '0;
            m_axi_acp_arlen  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                error            <= 1'b0;
                rem              <= length;
                m_axi_acp_araddr <= start_addr;
                m_axi_acp_arlen  <= 4'(first_beats - 5'd1);
            end
            if (state == ADDR && m_axi_acp_arready) bcnt <= '0;
            if (beat_ok) begin
                bcnt <= bcnt + 5'd1;
                if (beat_err) error <= 1'b1;
            end
            if (last_ok) begin
                rem              <= rem_n;
                m_axi_acp_araddr <= addr_n;
                m_axi_acp_arlen  <= 4'(next_beats - 5'd1);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = length == '0 ? DONE : ADDR;
            ADDR:    if (m_axi_acp_arready) state_n = DATA;
            DATA:    if (last_ok) state_n = rem_n == '0 ? DONE : ADDR;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_rd_engine.sv
// tb_dma_rd_engine: scoreboard bench with an AXI read slave model and expected AR/data queues.
module tb_dma_rd_engine;
    logic        clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [23:0] length = '0;
    logic        busy, done, error;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid, arready;
    logic [2:0]  arid, arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache, arqos;
    logic [4:0]  aruser;
    logic [63:0] rdata, mm2s_data;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, mm2s_valid, mm2s_ready;

    dma_rd_engine dut (
        .m_axi_acp_aclk(clk), .axi_reset(axi_reset), .start(start), .src_addr(src_addr),
        .length(length), .busy(busy), .done(done), .error(error),
        .m_axi_acp_araddr(araddr), .m_axi_acp_arlen(arlen), .m_axi_acp_arvalid(arvalid),
        .m_axi_acp_arready(arready), .m_axi_acp_arid(arid), .m_axi_acp_arsize(arsize),
        .m_axi_acp_arburst(arburst), .m_axi_acp_arlock(arlock), .m_axi_acp_arcache(arcache),
        .m_axi_acp_arprot(arprot), .m_axi_acp_arqos(arqos), .m_axi_acp_aruser(aruser),
        .m_axi_acp_rdata(rdata), .m_axi_acp_rresp(rresp), .m_axi_acp_rlast(rlast),
        .m_axi_acp_rvalid(rvalid), .m_axi_acp_rready(rready),
        .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(mm2s_ready)
    );

    initial forever #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [63:0] exp_data[$];
    logic [35:0] exp_ar[$], burst_q[$];
    bit          rnd = 1'b0, r_active = 1'b0, r_take, ar_wait = 1'b0;
    int          err_beat = -1, beat_ctr = 0, r_left = 0, ar_seen = 0, beats_seen = 0;
    logic [31:0] r_addr = '0;
    logic [3:0]  r_len;
    logic [35:0] ar_saved;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    // Slave + monitor: sample on negedge, drive just after posedge
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; mm2s_ready = 0;
        forever begin
            @(negedge clk);
            r_take = rvalid && rready;
            if (ar_wait) check("ar_stable", {arvalid, araddr, arlen}, {1'b1, ar_saved});
            if (arvalid && arready) begin
                ar_seen++;
                if (exp_ar.size() == 0) check("ar_unexpected", 64'(ar_seen), 64'd0);
                else check("ar", {araddr, arlen}, exp_ar.pop_front());
                burst_q.push_back({araddr, arlen});
            end
            ar_wait  = arvalid && !arready;
            ar_saved = {araddr, arlen};
            if (mm2s_valid && mm2s_ready) begin
                beats_seen++;
                if (exp_data.size() == 0) check("data_unexpected", 64'(beats_seen), 64'd0);
                else check("data", mm2s_data, exp_data.pop_front());
            end
            @(posedge clk);
            #1;
            if (r_take) begin
                r_addr += 32'd8;
                r_left--;
                beat_ctr++;
                if (r_left == 0) r_active = 1'b0;
            end
            if (!r_active && burst_q.size() > 0) begin
                {r_addr, r_len} = burst_q.pop_front();
                r_left   = int'(r_len) + 1;
                r_active = 1'b1;
            end
            rvalid     = r_active && ((rvalid && !r_take) || !rnd || $urandom_range(2) != 0);
            rdata      = mem(r_addr);
            rlast      = r_left == 1;
            rresp      = beat_ctr == err_beat ? 2'b10 : 2'b00;
            arready    = !rnd || $urandom_range(1) == 1;
            mm2s_ready = !rnd || $urandom_range(3) != 0;
        end
    end

    task automatic prep(input logic [31:0] a, input int len, input bit r, input int eb);
        logic [31:0] x;
        int rm, b, room;
        x  = a & ~32'h7;
        rm = len;
        for (int i = 0; i < len; i++) exp_data.push_back(mem(x + 32'(8 * i)));
        while (rm > 0) begin
            room = (4096 - int'(x[11:0])) / 8;
            b = rm < 16 ? rm : 16;
            if (room < b) b = room;
            exp_ar.push_back({x, 4'(b - 1)});
            x  += 32'(8 * b);
            rm -= b;
        end
        rnd = r; err_beat = eb; beat_ctr = 0; ar_seen = 0; beats_seen = 0;
        @(posedge clk);
        #1;
        src_addr = a; length = 24'(len); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_c1", 64'(busy), 64'd1);
        check("err_clr", 64'(error), 64'd0);
        if (len > 0) check("arvalid_c1", 64'(arvalid), 64'd1);
    endtask

    task automatic run(input logic [31:0] a, input int len, input bit r, input int eb,
                       input bit exp_err, input int exp_ars);
        int cyc;
        prep(a, len, r, eb);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
        check("err_at_done", 64'(error), 64'(exp_err));
        check("beat_cnt", 64'(beats_seen), 64'(len));
        check("ar_cnt", 64'(ar_seen), 64'(exp_ars));
        check("data_left", 64'(exp_data.size()), 64'd0);
        @(negedge clk);
        check("done_pulse", {busy, done}, 64'd0);
        check("err_sticky", 64'(error), 64'(exp_err));
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, error, arvalid, rready, mm2s_valid}, 64'd0);
        check("rst_ar", {araddr, arlen}, 64'd0);
        check("ar_consts", {arid, arsize, arburst, arlock, arcache, arprot, arqos, aruser},
              {3'b100, 3'd3, 2'b01, 2'b00, 4'b0001, 3'b010, 4'd0, 5'd0});
        @(posedge clk);
        #1;
        axi_reset = 1'b0;

        run(32'h1000_0000, 40, 1'b0, -1, 1'b0, 3);
        run(32'h0000_0FE0, 16, 1'b0, -1, 1'b0, 2);

        prep(32'h0000_0400, 0, 1'b0, -1);
        check("len0_done_c1", {done, arvalid}, 64'b10);
        @(negedge clk);
        check("len0_c2", {busy, done}, 64'd0);
        check("len0_no_ar", 64'(ar_seen), 64'd0);

        run(32'h3000_0F40, 100, 1'b1, -1, 1'b0, 7);
        run(32'h0000_0100, 20, 1'b0, 5, 1'b1, 2);
        repeat (3) @(negedge clk);
        check("err_hold", 64'(error), 64'd1);

        prep(32'h2000_0000, 40, 1'b0, -1);
        cyc = 0;
        while (beats_seen < 5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_data", 64'(mm2s_valid), 64'd1);
        @(posedge clk);
        #1;
        axi_reset = 1'b1;
        @(posedge clk);
        #1;
        axi_reset = 1'b0;
        @(negedge clk);
        exp_data.delete(); exp_ar.delete(); burst_q.delete();
        r_active = 1'b0; r_left = 0;
        check("midrst_status", {busy, done, error, arvalid, rready, mm2s_valid}, 64'd0);
        check("midrst_ar", {araddr, arlen}, 64'd0);
        repeat (2) @(negedge clk);
        run(32'h0000_0107, 4, 1'b0, -1, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
